bit_serial_adder_ctrl: RTL and testbench

//  Sequencer that reuses one 1-bit full-adder cell to add two WIDTH-bit operands LSB-first, one bit per clock.

---
 rtl/bit_serial_adder_ctrl_pkg.sv | 7 +
 rtl/bit_serial_adder_ctrl_if.sv | 25 ++
 rtl/bit_serial_adder_ctrl_fa_cell.sv | 13 +
 rtl/bit_serial_adder_ctrl.sv | 62 ++++++
 tb/tb_bit_serial_adder_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/bit_serial_adder_ctrl_pkg.sv
// bit_serial_adder_ctrl_pkg: state encodings and bit-counter sizing for the serial adder
package bit_serial_adder_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
    function automatic int cnt_w(input int w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// bit_serial_adder_ctrl_if: requester-side handshake and operand/result bundle
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface bit_serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
`endif
    logic busy;
    logic done;
    logic [WIDTH-1:0] sum;
    logic cout;
    modport master(
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin, input busy, done, sum, cout);
    modport slave(
`ifdef SERIAL_ADDER_SUB_EN
        input sub,
`endif
        input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// fa_cell: one-bit full adder reused for every bit position
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    always_comb begin
        s = a ^ b ^ cin;
        c = (a & b) | (cin & (a ^ b));
    end
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// bit_serial_adder_ctrl: LSB-first serial adder sequencer around a single fa_cell
// SERIAL_ADDER_SUB_EN enables a - b via ~b and forced carry-in.
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    bit_serial_adder_ctrl_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, nxt;
    logic [WIDTH-1:0] sra, srb, pr, b_ld;
    logic [CW-1:0] cnt;
    logic carry, c_ld, s, c, last, accept;
    fa_cell u_fa (.a(sra[0]), .b(srb[0]), .cin(carry), .s(s), .c(c));
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_ld = bus.sub ? ~bus.b : bus.b;
        c_ld = bus.sub ? 1'b1 : bus.cin;
`else
        b_ld = bus.b;
        c_ld = bus.cin;
`endif
        last = cnt == CW'(WIDTH - 1);
        accept = state == ST_IDLE && bus.start;
        nxt = state == ST_IDLE ? (bus.start ? ST_RUN : ST_IDLE)
            : state == ST_RUN ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
        bus.busy = state != ST_IDLE;
        bus.done = state == ST_DONE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else state <= nxt;
    // Result bits enter pr at the MSB; sum is only updated once all bits are in.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sra <= '0;
            srb <= '0;
            pr <= '0;
            carry <= 1'b0;
            cnt <= '0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
        end else if (accept) begin
            sra <= bus.a;
            srb <= b_ld;
            carry <= c_ld;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            sra <= sra >> 1;
            srb <= srb >> 1;
            pr <= {s, pr[WIDTH-1:1]};
            carry <= c;
            cnt <= cnt + CW'(1);
            if (last) begin
                bus.sum <= {s, pr[WIDTH-1:1]};
                bus.cout <= c;
            end
        end
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb_bit_serial_adder_ctrl: directed checks at WIDTH=8 plus exhaustive WIDTH=4 sweep
module tb_bit_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errs = 0;
    int checks = 0;
    always #5 clk = ~clk;
    bit_serial_adder_ctrl_if #(.WIDTH(8)) v8 ();
    bit_serial_adder_ctrl_if #(.WIDTH(4)) v4 ();
    bit_serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(v8));
    bit_serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(v4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts,
                        output int lat, output logic bz);
        v8.start = 1'b1;
        v8.a = ta;
        v8.b = tb_;
        v8.cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        v8.sub = ts;
`else
        if (ts) $display("sub requested without SERIAL_ADDER_SUB_EN");
`endif
        @(posedge clk);
        #1 v8.start = 1'b0;
        bz = v8.busy;
        lat = 0;
        while (!v8.done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    int lat, nd, dlat;
    logic bz;
    logic [7:0] sumrun;
    logic [4:0] exp5;

    initial begin
        v8.start = 1'b0; v8.a = '0; v8.b = '0; v8.cin = 1'b0;
        v4.start = 1'b0; v4.a = '0; v4.b = '0; v4.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        v8.sub = 1'b0;
        v4.sub = 1'b0;
`endif
        #12;
        chk("rst_busy", 32'(v8.busy), 0);
        chk("rst_done", 32'(v8.done), 0);
        chk("rst_sum", 32'(v8.sum), 0);
        chk("rst_cout", 32'(v8.cout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("idle_busy", 32'(v8.busy), 0);

        run8(8'h35, 8'h4A, 1'b0, 1'b0, lat, bz);
        chk("add1_busy_run", 32'(bz), 1);
        chk("add1_lat", 32'(lat), 8);
        chk("add1_sum", 32'(v8.sum), 32'h7F);
        chk("add1_cout", 32'(v8.cout), 0);
        chk("add1_busy_done", 32'(v8.busy), 1);
        @(posedge clk);
        #1 chk("add1_done_pulse", 32'(v8.done), 0);
        chk("add1_busy_idle", 32'(v8.busy), 0);

        run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bz);
        chk("add2_lat", 32'(lat), 8);
        chk("add2_sum", 32'(v8.sum), 32'h00);
        chk("add2_cout", 32'(v8.cout), 1);
        @(posedge clk);
        #1;
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bz);
        chk("add3_lat", 32'(lat), 8);
        chk("add3_sum", 32'(v8.sum), 32'hFF);
        chk("add3_cout", 32'(v8.cout), 1);
        @(posedge clk);
        #1;

        // Second start mid-run must be dropped.
        v8.start = 1'b1; v8.a = 8'h35; v8.b = 8'h4A; v8.cin = 1'b0;
        @(posedge clk);
        #1 v8.start = 1'b0;
        nd = 0; dlat = 0; sumrun = '0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) sumrun = v8.sum;
            if (i == 3) begin v8.start = 1'b1; v8.a = 8'h00; v8.b = 8'h00; end
            if (i == 4) v8.start = 1'b0;
            if (v8.done) begin nd++; dlat = i; end
        end
        chk("ign_sum_held", 32'(sumrun), 32'hFF);
        chk("ign_ndone", 32'(nd), 1);
        chk("ign_lat", 32'(dlat), 8);
        chk("ign_sum", 32'(v8.sum), 32'h7F);
        chk("ign_cout", 32'(v8.cout), 0);

        v8.start = 1'b1; v8.a = 8'hFF; v8.b = 8'h01; v8.cin = 1'b0;
        @(posedge clk);
        #1 v8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(v8.busy), 0);
        chk("abort_done", 32'(v8.done), 0);
        chk("abort_sum", 32'(v8.sum), 0);
        chk("abort_cout", 32'(v8.cout), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (v8.done) nd++;
        end
        chk("abort_nodone", 32'(nd), 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bz);
        chk("post_lat", 32'(lat), 8);
        chk("post_sum", 32'(v8.sum), 32'h00);
        chk("post_cout", 32'(v8.cout), 1);
        @(posedge clk);
        #1;

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h10, 8'h01, 1'b0, 1'b1, lat, bz);
        chk("sub1_sum", 32'(v8.sum), 32'h0F);
        chk("sub1_cout", 32'(v8.cout), 1);
        @(posedge clk);
        #1;
        run8(8'h01, 8'h02, 1'b0, 1'b1, lat, bz);
        chk("sub2_sum", 32'(v8.sum), 32'hFF);
        chk("sub2_cout", 32'(v8.cout), 0);
        @(posedge clk);
        #1 v8.sub = 1'b0;
`endif

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 2; z++) begin
                    v4.start = 1'b1;
                    v4.a = 4'(x);
                    v4.b = 4'(y);
                    v4.cin = 1'(z);
                    @(posedge clk);
                    #1 v4.start = 1'b0;
                    nd = 0;
                    for (int i = 1; i <= 5; i++) begin
                        @(posedge clk);
                        #1 if (v4.done) nd++;
                    end
                    exp5 = 5'(x + y + z);
                    chk($sformatf("w4_%0h_%0h_%0d", x, y, z), 32'({v4.cout, v4.sum}), 32'(exp5));
                    chk("w4_ndone", 32'(nd), 1);
                end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
